// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data RAM port arbiter.
// Holds the arbiter state and owner encodings, the default widths and burst
// lengths, and a helper that sizes the beat counter.
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_WORD_W  = 32;
    localparam int DEF_I_BURST = 4;
    localparam int DEF_D_BURST = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IBUS = 2'd1,
        ARB_DBUS = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Counter width for the longer of the two bursts. It is never narrower
    // than one bit, so a single-beat burst still has a legal counter.
    function automatic int beat_cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_beat_counter.sv
// Beat counter for one RAM burst.
// Ports:
//   clk, nrst   - clock; synchronous active-low reset
//   clr_i       - return the count to zero (end of burst or abort)
//   inc_i       - advance by one completed beat
//   last_idx_i  - index of the final beat of the current burst (length-1)
//   count_o     - beats completed so far in this burst
//   last_o      - the beat now in flight is the final one
module mem_port_arbiter_beat_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] last_idx_i,
    output logic [CNT_W-1:0] count_o,
    output logic             last_o
);

    logic [CNT_W-1:0] count_q;

    // Clear has priority; the owner clears on the final beat instead of
    // incrementing, so the count never passes last_idx_i.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (inc_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;
    assign last_o  = (count_q == last_idx_i);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the single RAM port between the icache refill path and the
// dcache refill/writeback path. Ownership is granted per burst with
// round-robin priority. One idle cycle always separates bursts, and a burst
// can only end early when its requester drops its request.
// Ports:
//   clk, nrst                     - clock; synchronous active-low reset
//   i_req_i, i_addr_i             - icache miss request and word address
//   i_word_ready_o, i_rdata_o     - beat strobe and read data to the icache
//   d_req_i, d_we_i, d_addr_i,
//   d_wdata_i                     - dcache request, direction, address, data
//   d_word_ready_o, d_rdata_o     - beat strobe and read data to the dcache
//   ram_req_o, ram_we_o,
//   ram_addr_o, ram_wdata_o       - request lines to the RAM
//   ram_word_ready_i, ram_rdata_i - beat completion and read data from RAM
//   grant_i_o, grant_d_o          - current owner of the port
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int WORD_W  = DEF_WORD_W,
    parameter int I_BURST = DEF_I_BURST,
    parameter int D_BURST = DEF_D_BURST
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_word_ready_o,
    output logic [WORD_W-1:0] i_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [WORD_W-1:0] d_wdata_i,
    output logic              d_word_ready_o,
    output logic [WORD_W-1:0] d_rdata_o,
    output logic              ram_req_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [WORD_W-1:0] ram_wdata_o,
    input  logic              ram_word_ready_i,
    input  logic [WORD_W-1:0] ram_rdata_i,
    output logic              grant_i_o,
    output logic              grant_d_o
);

    localparam int CNT_W = beat_cnt_width(I_BURST, D_BURST);
    localparam logic [CNT_W-1:0] I_LAST = CNT_W'(I_BURST - 1);
    localparam logic [CNT_W-1:0] D_LAST = CNT_W'(D_BURST - 1);

    arb_state_t       state_q, state_d;
    owner_t           last_owner_q, last_owner_d;
    logic             cnt_clr, cnt_inc, beat_last;
    logic [CNT_W-1:0] last_idx;
    logic [CNT_W-1:0] beat_count;

    mem_port_arbiter_beat_counter #(
        .CNT_W(CNT_W)
    ) u_beat_counter (
        .clk       (clk),
        .nrst      (nrst),
        .clr_i     (cnt_clr),
        .inc_i     (cnt_inc),
        .last_idx_i(last_idx),
        .count_o   (beat_count),
        .last_o    (beat_last)
    );

    // last_owner resets to D so the icache wins the first tie.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q      <= ARB_IDLE;
            last_owner_q <= OWN_D;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
        end
    end

    // Every RAM-facing and requester-facing output is gated by the owner's
    // request, so an abort drops ram_req in the same cycle and a beat that
    // completes in that cycle is not forwarded.
    always_comb begin
        state_d        = state_q;
        last_owner_d   = last_owner_q;
        cnt_clr        = 1'b0;
        cnt_inc        = 1'b0;
        last_idx       = I_LAST;
        ram_req_o      = 1'b0;
        ram_we_o       = 1'b0;
        ram_addr_o     = '0;
        ram_wdata_o    = '0;
        i_word_ready_o = 1'b0;
        i_rdata_o      = '0;
        d_word_ready_o = 1'b0;
        d_rdata_o      = '0;

        case (state_q)
            ARB_IDLE: begin
                // A stray ram_word_ready here is simply not looked at.
                if (i_req_i && (!d_req_i || last_owner_q == OWN_D)) begin
                    state_d = ARB_IBUS;
                end else if (d_req_i) begin
                    state_d = ARB_DBUS;
                end
            end
            ARB_IBUS: begin
                last_idx = I_LAST;
                if (i_req_i) begin
                    ram_req_o      = 1'b1;
                    ram_addr_o     = i_addr_i;
                    i_word_ready_o = ram_word_ready_i;
                    i_rdata_o      = ram_rdata_i;
                    cnt_inc        = ram_word_ready_i && !beat_last;
                    if (ram_word_ready_i && beat_last) begin
                        state_d      = ARB_IDLE;
                        last_owner_d = OWN_I;
                        cnt_clr      = 1'b1;
                    end
                end else begin
                    state_d      = ARB_IDLE;
                    last_owner_d = OWN_I;
                    cnt_clr      = 1'b1;
                end
            end
            ARB_DBUS: begin
                last_idx = D_LAST;
                if (d_req_i) begin
                    ram_req_o      = 1'b1;
                    ram_we_o       = d_we_i;
                    ram_addr_o     = d_addr_i;
                    ram_wdata_o    = d_wdata_i;
                    d_word_ready_o = ram_word_ready_i;
                    d_rdata_o      = ram_rdata_i;
                    cnt_inc        = ram_word_ready_i && !beat_last;
                    if (ram_word_ready_i && beat_last) begin
                        state_d      = ARB_IDLE;
                        last_owner_d = OWN_D;
                        cnt_clr      = 1'b1;
                    end
                end else begin
                    state_d      = ARB_IDLE;
                    last_owner_d = OWN_D;
                    cnt_clr      = 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    // The grants come straight from the state register, so each grant rises
    // the cycle after the request is seen.
    assign grant_i_o = (state_q == ARB_IBUS);
    assign grant_d_o = (state_q == ARB_DBUS);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int IB = 4;
    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        nrst;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_word_ready, d_word_ready;
    logic [31:0] i_rdata, d_rdata;
    logic        ram_req, ram_we, ram_word_ready;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        grant_i, grant_d;

    mem_port_arbiter #(
        .ADDR_W(32), .WORD_W(32), .I_BURST(IB), .D_BURST(DB)
    ) dut (
        .clk             (clk),
        .nrst            (nrst),
        .i_req_i         (i_req),
        .i_addr_i        (i_addr),
        .i_word_ready_o  (i_word_ready),
        .i_rdata_o       (i_rdata),
        .d_req_i         (d_req),
        .d_we_i          (d_we),
        .d_addr_i        (d_addr),
        .d_wdata_i       (d_wdata),
        .d_word_ready_o  (d_word_ready),
        .d_rdata_o       (d_rdata),
        .ram_req_o       (ram_req),
        .ram_we_o        (ram_we),
        .ram_addr_o      (ram_addr),
        .ram_wdata_o     (ram_wdata),
        .ram_word_ready_i(ram_word_ready),
        .ram_rdata_i     (ram_rdata),
        .grant_i_o       (grant_i),
        .grant_d_o       (grant_d)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model of who owns the port: 0 = nobody, 1 = icache, 2 = dcache.
    int m_owner = 0;
    int m_beats = 0;
    int m_last  = 2;

    int  cyc = 0;
    bit  every2 = 1'b0;   // RAM answers every second cycle when set
    bit  ones_data = 1'b0;
    int  dut_ipulses = 0, dut_dpulses = 0;
    bit  rec = 1'b0;
    int  seq_len = 0;
    logic [3:0] seq = '0;
    logic gi_prev = 1'b0, gd_prev = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: compare every output against the model at the
    // falling edge, then advance the model at the rising edge.
    task automatic cycle();
        logic        act, e_iwr, e_dwr;
        logic [31:0] e_addr, e_wdata, e_ird, e_drd;
        logic        e_we;
        @(negedge clk);
        act     = (m_owner == 1 && i_req) || (m_owner == 2 && d_req);
        e_we    = (act && m_owner == 2) ? d_we : 1'b0;
        e_addr  = !act ? 32'h0 : (m_owner == 1 ? i_addr : d_addr);
        e_wdata = (act && m_owner == 2) ? d_wdata : 32'h0;
        e_iwr   = (m_owner == 1) && i_req && ram_word_ready;
        e_dwr   = (m_owner == 2) && d_req && ram_word_ready;
        e_ird   = (m_owner == 1 && i_req) ? ram_rdata : 32'h0;
        e_drd   = (m_owner == 2 && d_req) ? ram_rdata : 32'h0;
        chk("grant_i", 32'(grant_i), 32'(m_owner == 1));
        chk("grant_d", 32'(grant_d), 32'(m_owner == 2));
        chk("ram_req", 32'(ram_req), 32'(act));
        chk("ram_we", 32'(ram_we), 32'(e_we));
        chk("ram_addr", ram_addr, e_addr);
        chk("ram_wdata", ram_wdata, e_wdata);
        chk("i_word_ready", 32'(i_word_ready), 32'(e_iwr));
        chk("d_word_ready", 32'(d_word_ready), 32'(e_dwr));
        chk("i_rdata", i_rdata, e_ird);
        chk("d_rdata", d_rdata, e_drd);
        if (e_iwr) $display("beat I #%0d addr=%h rdata=%h", m_beats, i_addr, ram_rdata);
        if (e_dwr) $display("beat D #%0d we=%0d addr=%h wdata=%h rdata=%h",
                            m_beats, d_we, d_addr, d_wdata, ram_rdata);
        if (i_word_ready) dut_ipulses++;
        if (d_word_ready) dut_dpulses++;
        if (rec && seq_len < 4) begin
            if (grant_i && !gi_prev) begin seq = {seq[2:0], 1'b0}; seq_len++; end
            if (grant_d && !gd_prev) begin seq = {seq[2:0], 1'b1}; seq_len++; end
        end
        gi_prev = grant_i;
        gd_prev = grant_d;
        @(posedge clk);
        if (!nrst) begin
            m_owner = 0; m_beats = 0; m_last = 2;
        end else if (m_owner == 0) begin
            m_beats = 0;
            if (i_req && (!d_req || m_last == 2)) m_owner = 1;
            else if (d_req)                       m_owner = 2;
        end else begin
            if (!((m_owner == 1) ? i_req : d_req)) begin
                m_last = m_owner; m_owner = 0; m_beats = 0;
            end else if (ram_word_ready) begin
                m_beats++;
                if (m_beats == ((m_owner == 1) ? IB : DB)) begin
                    m_last = m_owner; m_owner = 0; m_beats = 0;
                end
            end
        end
        #1;
        cyc++;
    endtask

    // Present per-beat addresses/data and a RAM response, then run a cycle.
    task automatic drive();
        i_addr         = 32'h100  + 32'(4 * ((m_owner == 1) ? m_beats : 0));
        d_addr         = 32'h2000 + 32'(4 * ((m_owner == 2) ? m_beats : 0));
        d_wdata        = 32'hDEADBEEF + 32'((m_owner == 2) ? m_beats : 0);
        ram_word_ready = every2 ? cyc[0] : 1'b1;
        ram_rdata      = ones_data ? 32'hFFFFFFFF : $urandom;
        cycle();
    endtask

    task automatic run_until_idle(input string nm, input int max);
        int n;
        n = 0;
        do begin
            drive();
            n++;
        end while (m_owner != 0 && n < max);
        if (m_owner != 0) begin
            checks++; errors++;
            $display("FAIL %s: timeout after %0d cycles, still busy", nm, n);
        end
    endtask

    task automatic run_until_beat(input string nm, input int owner, input int beat);
        int n;
        n = 0;
        while (!(m_owner == owner && m_beats == beat) && n < 40) begin
            drive();
            n++;
        end
        if (!(m_owner == owner && m_beats == beat)) begin
            checks++; errors++;
            $display("FAIL %s: timeout waiting for beat %0d", nm, beat);
        end
    endtask

    initial begin
        nrst = 1'b0; i_req = 0; d_req = 0; d_we = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; ram_word_ready = 0; ram_rdata = 0;
        drive(); drive();
        nrst = 1'b1;
        chk("reset_grant_i", 32'(grant_i), 32'd0);
        chk("reset_grant_d", 32'(grant_d), 32'd0);
        chk("reset_ram_req", 32'(ram_req), 32'd0);

        // Single icache miss, RAM ready every second cycle.
        every2 = 1'b1;
        i_req = 1'b1;
        dut_ipulses = 0; dut_dpulses = 0;
        drive();
        chk("t1_grant_latency", 32'(grant_i), 32'd1);
        run_until_idle("t1_burst", 40);
        i_req = 1'b0;
        chk("t1_i_pulses", 32'(dut_ipulses), 32'd4);
        chk("t1_d_pulses", 32'(dut_dpulses), 32'd0);
        drive();
        chk("t1_idle_grant", 32'(grant_i), 32'd0);

        // Both requesters from a fresh reset, held: I, D, I, D.
        every2 = 1'b0;
        nrst = 1'b0; drive(); nrst = 1'b1;
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        rec = 1'b1; seq_len = 0; seq = '0;
        for (int k = 0; k < 60 && !(seq_len == 4 && m_owner == 0); k++) drive();
        rec = 1'b0;
        i_req = 1'b0; d_req = 1'b0;
        chk("t2_grant_count", 32'(seq_len), 32'd4);
        chk("t2_order_IDID", 32'(seq), 32'h5);
        drive();

        // dcache writeback; icache miss arrives at beat 1 and waits.
        d_req = 1'b1; d_we = 1'b1;
        dut_dpulses = 0;
        run_until_beat("t3_beat1", 2, 1);
        i_req = 1'b1;
        run_until_idle("t3_wb", 40);
        d_req = 1'b0; d_we = 1'b0;
        chk("t3_d_pulses", 32'(dut_dpulses), 32'd4);
        chk("t3_i_waiting", 32'(grant_i), 32'd0);
        drive();
        chk("t3_i_granted", 32'(grant_i), 32'd1);
        run_until_idle("t3_i", 40);
        i_req = 1'b0;
        drive();

        // Abort: icache drops its request after 2 beats; dcache is pending.
        i_req = 1'b1;
        drive();
        d_req = 1'b1;
        run_until_beat("t4_beat2", 1, 2);
        i_req = 1'b0;
        drive();
        chk("t4_abort_grant_i", 32'(grant_i), 32'd0);
        drive();
        chk("t4_d_granted", 32'(grant_d), 32'd1);
        run_until_idle("t4_d", 40);
        d_req = 1'b0;
        drive();

        // Reset during beat 2 of a dcache burst.
        d_req = 1'b1;
        run_until_beat("t5_beat2", 2, 2);
        nrst = 1'b0;
        drive();
        nrst = 1'b1; d_req = 1'b0;
        chk("t5_rst_grant_d", 32'(grant_d), 32'd0);
        chk("t5_rst_ram_req", 32'(ram_req), 32'd0);
        chk("t5_rst_d_ready", 32'(d_word_ready), 32'd0);
        i_req = 1'b1; d_req = 1'b1;
        drive();
        chk("t5_i_first", 32'(grant_i), 32'd1);
        run_until_idle("t5_i", 40);
        i_req = 1'b0;
        run_until_idle("t5_d", 40);
        d_req = 1'b0;

        // Spurious RAM ready while idle.
        ones_data = 1'b1;
        repeat (3) drive();
        chk("t6_i_ready", 32'(i_word_ready), 32'd0);
        chk("t6_d_rdata", d_rdata, 32'd0);
        chk("t6_grant_i", 32'(grant_i), 32'd0);
        ones_data = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single instruction/data RAM port between two requesters:
  - the instruction-cache refill path (fetch stage; miss, address, word/word_ready);
  - the data-cache refill/writeback path (MEM stage).
- Grants at burst granularity with round-robin priority, routes address/data/write-enable to RAM and returns word_ready/data only to the owner.
- Sits between the fetch/MEM stages and the external RAM model.

Parameters:
- ADDR_W, 32 (`pc_size): RAM address width
- WORD_W, 32 (`memory_word): RAM data word width
- I_BURST, 4: words per instruction refill (power of 2, 1..16)
- D_BURST, 4: words per data refill/writeback (power of 2, 1..16)

Ports:
- clk  in  1  clock
- nrst  in  1  reset, synchronous, active-low
- i_req  in  1  icache miss; held high until final word received
- i_addr  in  ADDR_W  icache word address, valid while i_req
- i_word_ready  out  1  word valid for icache (pulse per beat)
- i_rdata  out  WORD_W  read data to icache
- d_req  in  1  dcache transfer request; held until final beat
- d_we  in  1  1 = writeback burst, 0 = refill; stable while d_req
- d_addr  in  ADDR_W  dcache word address per beat
- d_wdata  in  WORD_W  write data per beat
- d_word_ready  out  1  beat completed for dcache
- d_rdata  out  WORD_W  read data to dcache
- ram_req  out  1  RAM access request
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  WORD_W  RAM write data
- ram_word_ready  in  1  RAM beat done (read data valid / write accepted)
- ram_rdata  in  WORD_W  RAM read data
- grant_i  out  1  icache owns port
- grant_d  out  1  dcache owns port

Behaviour:
- Reset:
  - state IDLE; beat counter 0; last_owner = D, so I wins the first tie.
  - All outputs 0.
- FSM states:
  - IDLE:
    - only i_req -> I_BUS; only d_req -> D_BUS.
    - both -> the requester that is not last_owner.
    - grant_* registered: asserted the cycle after the request is seen.
  - I_BUS:
    - grant_i=1; ram_req=1; ram_we=0; ram_addr=i_addr.
    - each ram_word_ready: i_word_ready=1 the same cycle (combinational), i_rdata=ram_rdata, beat++.
    - at beat==I_BURST-1 with ram_word_ready: -> IDLE, last_owner=I, beat=0.
  - D_BUS: as I_BUS with D_BURST, ram_we=d_we, ram_addr=d_addr, ram_wdata=d_wdata; d_word_ready/d_rdata routed.
- Non-owner: *_word_ready=0 and *_rdata=0 regardless of RAM activity.
- IDLE outputs: ram_req=0, ram_we=0, ram_addr=0, ram_wdata=0.
- Inter-burst gap:
  - one IDLE cycle always separates bursts, including back-to-back bursts from the same requester.
  - round-robin is evaluated in that cycle.
- Burst atomicity: no preemption. A higher-priority request arriving mid-burst waits.
- Starvation bound: a waiting requester is granted within one foreign burst plus one cycle.
- Requester drops req mid-burst (abort):
  - ram_req deasserts combinationally that cycle.
  - Next edge: -> IDLE, beat=0; last_owner updated to the aborting requester.
  - A ram_word_ready in that same cycle is not forwarded.
- ram_word_ready in IDLE: ignored, no forwarding, no state change.
- Beat counter width: clog2(max(I_BURST, D_BURST)); never wraps past BURST-1.
- Reset mid-burst: same-edge return to IDLE, all outputs 0 on the next cycle; the in-flight RAM beat is discarded.
- d_we change mid-burst: illegal; the arbiter does not latch it (ram_we follows the input).

Decomposition:
- Shared package (constants.sv):
  - typedef enum logic[1:0] {ARB_IDLE, ARB_IBUS, ARB_DBUS} arb_state.
  - owner_t enum {OWN_I, OWN_D}.
  - default burst lengths as constants.
- Width macros reused: `pc_size, `memory_word.
- One sub-module: arb_beat_counter (load/increment/last-beat flag, parameterised length). The mux and FSM stay in the top.

Test Plan:
- Single icache miss: i_req=1, i_addr=0x100..0x10C, RAM ready every 2nd cycle -> grant_i the cycle after i_req; 4 i_word_ready pulses with matching ram_rdata; d outputs 0; IDLE after the 4th beat.
- Simultaneous i_req and d_req after reset -> I served first (4 beats), one IDLE cycle, then D_BUS. Repeat with both held -> strict I, D, I, D alternation.
- dcache writeback d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF.. -> ram_we=1 and ram_wdata track each beat; d_word_ready pulses 4 times; i_req raised at beat 1 waits until burst end plus 1 cycle.
- Abort: i_req dropped after 2 beats -> ram_req=0 that cycle, IDLE next; pending d_req granted the following cycle.
- nrst=0 during beat 2 of a D burst -> next cycle all outputs 0, state IDLE; fresh i_req after reset is granted first.
- Spurious ram_word_ready=1 in IDLE, rdata=0xFFFFFFFF -> i/d_word_ready stay 0, no state change.
